reg_file_sb: RTL and testbench

Parametrised multi-read-port register file with write bypass and a per-register pending-write scoreboard. It is the next-generation register file for the processor datapath. Decode reads NREAD operands per cycle and reserves destination registers at issue; writeback writes and releases them. Hazard status is reported per read port and as a total count of busy registers.

---
 rtl/reg_file_sb.sv | 113 +++++++++++
 tb/tb_reg_file_sb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read-port register file with write bypass and pending-write scoreboard
//
// Ports:
//   Clock    rising-edge clock
//   Reset    asynchronous active-low reset
//   RAddr    NREAD packed read addresses, port k at [k*RSIZE +: RSIZE]
//   RData    NREAD packed read data, port k at [k*DSIZE +: DSIZE]
//   RBusy    per-port flag: addressed register has an unresolved pending write
//   Wen      write enable; WAddr/WData give the target and value
//   Iss      reserve IssAddr (sets its busy bit)
//   Flush    clear all busy bits, data untouched
//   BusyCnt  registered count of busy registers
module reg_file_sb #(
    parameter int DSIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NREAD*RSIZE-1:0]   RAddr,
    output logic [NREAD*DSIZE-1:0]   RData,
    output logic [NREAD-1:0]         RBusy,
    input  logic                     Wen,
    input  logic [RSIZE-1:0]         WAddr,
    input  logic [DSIZE-1:0]         WData,
    input  logic                     Iss,
    input  logic [RSIZE-1:0]         IssAddr,
    input  logic                     Flush,
    output logic [RSIZE:0]           BusyCnt
);

    localparam int DEPTH = 1 << RSIZE;
    localparam logic [RSIZE:0] CNT_ONE = (RSIZE+1)'(1);
    localparam logic [RSIZE:0] CNT_MAX = (RSIZE+1)'((ZERO_REG != 0) ? DEPTH - 1 : DEPTH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    logic wr_eff;
    logic iss_eff;
    logic cnt_inc;
    logic cnt_dec;
    logic [RSIZE-1:0] ra;

    // R0 swallows writes and reservations when hardwired; Flush discards a same-cycle issue.
    assign wr_eff  = Wen && !((ZERO_REG != 0) && (WAddr == '0));
    assign iss_eff = Iss && !Flush && !((ZERO_REG != 0) && (IssAddr == '0));

    // Count moves only on real busy-bit transitions, so it tracks the popcount exactly.
    // A write that frees the register being re-reserved this cycle is not a release.
    assign cnt_inc = iss_eff && !busy[IssAddr];
    assign cnt_dec = wr_eff && busy[WAddr] && !(iss_eff && (IssAddr == WAddr));

    always_comb begin
        busy_next = busy;
        if (wr_eff) begin
            busy_next[WAddr] = 1'b0;
        end
        // Issue applied after write so a same-address reservation wins.
        if (iss_eff) begin
            busy_next[IssAddr] = 1'b1;
        end
        if (Flush) begin
            busy_next = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy    <= '0;
            BusyCnt <= '0;
        end else begin
            if (wr_eff) begin
                mem[WAddr] <= WData;
            end
            busy <= busy_next;
            if (Flush) begin
                BusyCnt <= '0;
            end else if (cnt_inc && !cnt_dec && (BusyCnt != CNT_MAX)) begin
                BusyCnt <= BusyCnt + CNT_ONE;
            end else if (cnt_dec && !cnt_inc && (BusyCnt != '0)) begin
                BusyCnt <= BusyCnt - CNT_ONE;
            end
        end
    end

    // Bypass is gated by Reset so reads stay zero while reset is held.
    always_comb begin
        RData = '0;
        RBusy = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = RAddr[k*RSIZE +: RSIZE];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                RData[k*DSIZE +: DSIZE] = '0;
                RBusy[k]                = 1'b0;
            end else if ((BYPASS != 0) && Reset && wr_eff && (WAddr == ra)) begin
                RData[k*DSIZE +: DSIZE] = WData;
                RBusy[k]                = 1'b0;
            end else begin
                RData[k*DSIZE +: DSIZE] = mem[ra];
                RBusy[k]                = busy[ra];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized self-checking bench for reg_file_sb against a behavioural model
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [15:0] raddr;
    logic        wen;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        iss;
    logic [3:0]  issaddr;
    logic        flush;

    logic [63:0] rd0, rd1, rd2;
    logic [3:0]  rb0, rb1, rb2;
    logic [4:0]  bc0, bc1;
    logic [2:0]  bc2;
    logic [7:0]  ra2;

    assign ra2 = {raddr[13:12], raddr[9:8], raddr[5:4], raddr[1:0]};

    // cfg0: bypass, zero reg; cfg1: no bypass, no zero reg; cfg2: 4-deep, bypass, zero reg
    reg_file_sb #(.DSIZE(16), .RSIZE(4), .NREAD(4), .BYPASS(1), .ZERO_REG(1)) u_a (
        .Clock(clk), .Reset(rst_n), .RAddr(raddr), .RData(rd0), .RBusy(rb0),
        .Wen(wen), .WAddr(waddr), .WData(wdata), .Iss(iss), .IssAddr(issaddr),
        .Flush(flush), .BusyCnt(bc0));

    reg_file_sb #(.DSIZE(16), .RSIZE(4), .NREAD(4), .BYPASS(0), .ZERO_REG(0)) u_b (
        .Clock(clk), .Reset(rst_n), .RAddr(raddr), .RData(rd1), .RBusy(rb1),
        .Wen(wen), .WAddr(waddr), .WData(wdata), .Iss(iss), .IssAddr(issaddr),
        .Flush(flush), .BusyCnt(bc1));

    reg_file_sb #(.DSIZE(16), .RSIZE(2), .NREAD(4), .BYPASS(1), .ZERO_REG(1)) u_c (
        .Clock(clk), .Reset(rst_n), .RAddr(ra2), .RData(rd2), .RBusy(rb2),
        .Wen(wen), .WAddr(waddr[1:0]), .WData(wdata), .Iss(iss), .IssAddr(issaddr[1:0]),
        .Flush(flush), .BusyCnt(bc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;

    logic [15:0] m_reg  [3][16];
    bit          m_busy [3][16];

    function automatic int amask(input int c);
        return (c == 2) ? 3 : 15;
    endfunction

    function automatic bit zr(input int c);
        return c != 1;
    endfunction

    function automatic bit bp(input int c);
        return c != 1;
    endfunction

    function automatic int popc(input int c);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_busy[c][i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 16; i++) begin
                m_reg[c][i]  = '0;
                m_busy[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        int wa, ia;
        for (int c = 0; c < 3; c++) begin
            wa = int'(waddr) & amask(c);
            ia = int'(issaddr) & amask(c);
            if (wen && !(zr(c) && wa == 0)) m_reg[c][wa] = wdata;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_busy[c][i] = 1'b0;
            end else begin
                if (wen && !(zr(c) && wa == 0)) m_busy[c][wa] = 1'b0;
                if (iss && !(zr(c) && ia == 0)) m_busy[c][ia] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        int a, wa;
        logic [15:0] ed, gd;
        logic eb, gb;
        logic [4:0] gc;
        for (int c = 0; c < 3; c++) begin
            wa = int'(waddr) & amask(c);
            for (int k = 0; k < 4; k++) begin
                a = (int'(raddr) >> (4 * k)) & amask(c);
                if (zr(c) && a == 0) begin
                    ed = '0; eb = 1'b0;
                end else if (bp(c) && rst_n && wen && wa == a) begin
                    ed = wdata; eb = 1'b0;
                end else begin
                    ed = m_reg[c][a]; eb = m_busy[c][a];
                end
                case (c)
                    0:       begin gd = rd0[k*16 +: 16]; gb = rb0[k]; end
                    1:       begin gd = rd1[k*16 +: 16]; gb = rb1[k]; end
                    default: begin gd = rd2[k*16 +: 16]; gb = rb2[k]; end
                endcase
                chk($sformatf("rdata c%0d p%0d a%0d", c, k, a), 64'(gd), 64'(ed));
                chk($sformatf("rbusy c%0d p%0d a%0d", c, k, a), 64'(gb), 64'(eb));
            end
            gc = (c == 0) ? bc0 : (c == 1) ? bc1 : {2'b00, bc2};
            chk($sformatf("busycnt c%0d", c), 64'(gc), 64'(popc(c)));
        end
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                         input logic i, input logic [3:0] ia, input logic f,
                         input logic [15:0] ra);
        wen = w; waddr = wa; wdata = wd; iss = i; issaddr = ia; flush = f; raddr = ra;
        #3;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset pulse in the middle of a cycle while the current inputs stay applied.
    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset rdata a", rd0, 64'h0);
        chk("reset cnt a", 64'(bc0), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        wen = 0; waddr = 0; wdata = 0; iss = 0; issaddr = 0; flush = 0; raddr = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-run after writing R3
        drive(1, 3, 16'h1234, 0, 0, 0, 16'h3333); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h3333);
        chk("r3 stored", 64'(rd0[15:0]), 64'h1234);
        mid_reset();

        // R0 hardwired
        drive(1, 0, 16'hFFFF, 0, 0, 0, 16'h0000);
        chk("r0 bypass zero", 64'(rd0[15:0]), 64'h0);
        tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h0000);
        chk("r0 stays zero", 64'(rd0[15:0]), 64'h0);
        chk("r0 plain reg", 64'(rd1[15:0]), 64'hFFFF);
        tick();

        // Bypass vs no bypass
        drive(1, 5, 16'hBEEF, 0, 0, 0, 16'h5555);
        chk("bypass same cycle", 64'(rd0[15:0]), 64'hBEEF);
        chk("nobypass old value", 64'(rd1[15:0]), 64'h0);
        tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h5555);
        chk("bypass next cycle", 64'(rd0[15:0]), 64'hBEEF);
        chk("nobypass next cycle", 64'(rd1[15:0]), 64'hBEEF);
        tick();

        // Scoreboard issue / release
        drive(0, 0, 16'h0, 1, 7, 0, 16'h7777); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h7777);
        chk("r7 busy", 64'(rb0[0]), 64'h1);
        chk("cnt after iss7", 64'(bc0), 64'h1);
        tick();
        drive(1, 7, 16'h0042, 0, 0, 0, 16'h7777);
        chk("r7 bypass not busy", 64'(rb0[0]), 64'h0);
        chk("r7 bypass data", 64'(rd0[15:0]), 64'h0042);
        chk("r7 nobypass busy", 64'(rb1[0]), 64'h1);
        tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h7777);
        chk("cnt after wb7", 64'(bc0), 64'h0);
        tick();

        // Simultaneous events
        drive(1, 4, 16'h4444, 1, 4, 0, 16'h4444); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h4444);
        chk("r4 data", 64'(rd0[15:0]), 64'h4444);
        chk("r4 busy", 64'(rb0[0]), 64'h1);
        chk("cnt r4", 64'(bc0), 64'h1);
        tick();
        drive(0, 0, 16'h0, 1, 4, 0, 16'h4444); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h4444);
        chk("cnt reissue r4", 64'(bc0), 64'h1);
        tick();
        drive(1, 4, 16'h5555, 1, 9, 0, 16'h9494); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h9494);
        chk("cnt iss9 wb4", 64'(bc0), 64'h1);
        chk("r4 released", 64'(rb0[0]), 64'h0);
        chk("r9 busy", 64'(rb0[1]), 64'h1);
        tick();
        drive(0, 0, 16'h0, 0, 0, 1, 16'h0); tick();

        // Saturation on the 4-deep instance
        for (int r = 1; r <= 3; r++) begin
            drive(0, 0, 16'h0, 1, 4'(r), 0, 16'h3210); tick();
        end
        drive(0, 0, 16'h0, 0, 0, 0, 16'h3210);
        chk("small cnt 3", 64'(bc2), 64'h3);
        tick();
        drive(0, 0, 16'h0, 1, 0, 0, 16'h3210); tick();
        drive(0, 0, 16'h0, 1, 1, 0, 16'h3210); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h3210);
        chk("small cnt sat", 64'(bc2), 64'h3);
        tick();
        drive(0, 0, 16'h0, 1, 2, 1, 16'h3210); tick();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h3210);
        chk("flush cnt small", 64'(bc2), 64'h0);
        chk("flush rbusy small", 64'(rb2), 64'h0);
        chk("flush cnt big", 64'(bc0), 64'h0);
        tick();

        // Multi-port: R1, R1, R0, WAddr
        drive(1, 1, 16'hA1A1, 0, 0, 0, 16'h0011); tick();
        drive(0, 0, 16'h0, 1, 1, 0, 16'h0011); tick();
        drive(1, 6, 16'h6666, 0, 0, 0, 16'h6011);
        chk("multiport data", rd0, 64'h6666_0000_A1A1_A1A1);
        chk("multiport busy", 64'(rb0), 64'h3);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  wa_r;
            logic [15:0] ra_r;
            wa_r = 4'($urandom);
            ra_r = 16'($urandom);
            if ($urandom_range(0, 9) < 3) ra_r[3:0] = wa_r;
            drive(($urandom_range(0, 9) < 4), wa_r, 16'($urandom),
                  ($urandom_range(0, 9) < 5), 4'($urandom),
                  ($urandom_range(0, 39) == 0), ra_r);
            if ($urandom_range(0, 299) == 0) mid_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
